seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameters SHALL be: DIGITS, default 8, number of multiplexed digits (2..8); SCAN_DIV, default 50000, clk cycles a digit is lit; BLANK_CYC, default 16, clk cycles all digits are dark between digits (>=1).
REQ-002 clk  input  1  single clock; all logic is rising-edge clocked.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 i_wr_valid  input  1  a write request is present.
REQ-005 i_wr_addr  input  3  digit index to write; values >= DIGITS are accepted and discarded.
REQ-006 i_wr_data  input  4  hex value 0x0..0xF for that digit.
REQ-007 i_wr_dp  input  1  decimal point for that digit, 1 = lit.
REQ-008 o_wr_ready  output  1  a write is accepted this cycle when i_wr_valid=1 and o_wr_ready=1.
REQ-009 i_dig_en  input  DIGITS  per-digit enable; 0 keeps that digit dark during its slot.
REQ-010 o_seg  output  8  active-low segments {a,b,c,d,e,f,g,dp}, MSB = a.
REQ-011 o_an  output  DIGITS  active-low digit select; at most one bit is 0.
REQ-012 o_frame_tick  output  1  one-cycle pulse at the end of each full scan frame.

Function
REQ-013 The FSM SHALL have states IDLE, BLANK and SHOW; IDLE -> BLANK after 1 cycle; BLANK -> SHOW after BLANK_CYC cycles; SHOW -> BLANK after SCAN_DIV cycles.
REQ-014 On SHOW->BLANK, the digit index SHALL advance by 1 and wrap from DIGITS-1 to 0; disabled digits still consume their slot, so frame length is exactly DIGITS*(BLANK_CYC+SCAN_DIV).
REQ-015 In IDLE and BLANK, o_an SHALL be all ones and o_seg SHALL be 8'hFF.
REQ-016 In SHOW with i_dig_en[idx]=1, o_an[idx] SHALL be 0, all other o_an bits 1, and o_seg SHALL be ~{decode(value[idx]),dp[idx]}.
REQ-017 In SHOW with i_dig_en[idx]=0, outputs SHALL match BLANK.
REQ-018 i_dig_en SHALL be sampled every cycle; a change takes effect on the next cycle.
REQ-019 Decode (a..g, 1=on) SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-020 o_wr_ready SHALL be 1 only in IDLE and BLANK, so a lit digit never changes mid-slot.
REQ-021 An accepted write SHALL update value[addr] and dp[addr] on that edge; if addr equals the next digit, the new value is shown in the following SHOW slot.
REQ-022 i_wr_valid=1 while o_wr_ready=0 SHALL have no effect; the requester holds the request until it is accepted.
REQ-023 o_frame_tick SHALL be 1 for exactly the cycle in which SHOW of digit DIGITS-1 completes.
REQ-024 o_seg, o_an, o_wr_ready and o_frame_tick SHALL be registered and SHALL have no combinational path from any input.
REQ-025 Cycle counters SHALL be sized to hold max(SCAN_DIV,BLANK_CYC)-1 and SHALL reload to 0 on every state change.

Reset
REQ-026 While rst=1: state=IDLE, idx=0, counters=0, all value/dp registers=0, o_seg=8'hFF, o_an=all ones, o_wr_ready=0, o_frame_tick=0.
REQ-027 rst asserted mid-slot SHALL darken the display on the next edge, and any write presented that cycle SHALL be discarded.

Structure
REQ-028 A shared package seg_pkg SHALL hold the state enum, the 16-entry decode constants, and the DIGITS/SCAN_DIV/BLANK_CYC defaults.
REQ-029 Decoding SHALL be a combinational sub-module seg_hex_dec (4-bit hex in, 7-bit a..g out, active-high); seg_scan_ctrl applies the inversion.

Verification (DIGITS=4, SCAN_DIV=4, BLANK_CYC=2)
REQ-030 Release rst at cycle 0 -> IDLE at cycle 0, BLANK at cycles 1-2, o_an=4'b1110 at cycles 3-6, then BLANK, then o_an=4'b1101; frame = 24 cycles; o_frame_tick pulses every 24 cycles.
REQ-031 Write addr 2, data 0xA, dp=1 during BLANK -> during digit 2's slot, o_an=4'b1011 and o_seg=8'b0001_0000.
REQ-032 Hold i_wr_valid=1 during SHOW -> o_wr_ready=0 and no update; the write is accepted on the first BLANK cycle; o_seg does not change within the slot.
REQ-033 i_dig_en=4'b0101 -> digits 1 and 3 stay dark, o_an never equals 4'b1101 or 4'b0111, and the frame is still 24 cycles.
REQ-034 Assert rst for 1 cycle mid-SHOW of digit 3 -> next edge o_an=4'hF and o_seg=8'hFF; the scan restarts at digit 0 and all digits show 0 (o_seg=8'b0000_0011).
REQ-035 Write addr 6 (>= DIGITS) -> accepted, no register changes, and the display is unchanged.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// parameter defaults, FSM state encoding and the hex-to-segment table.
package seg_pkg;

   localparam int DEF_DIGITS    = 8;
   localparam int DEF_SCAN_DIV  = 50000;
   localparam int DEF_BLANK_CYC = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } seg_state_t;

   // Segment patterns {a,b,c,d,e,f,g}, 1 = segment on, indexed by hex value
   localparam logic [6:0] SEG_DECODE [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational hex digit to active-high a..g segment decoder.
module seg_hex_dec
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = SEG_DECODE[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment display controller: scans DIGITS digits with
// a dark gap between slots and accepts digit writes only while nothing is lit.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int DIGITS    = DEF_DIGITS,
   parameter int SCAN_DIV  = DEF_SCAN_DIV,
   parameter int BLANK_CYC = DEF_BLANK_CYC
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_valid,
   input  logic [2:0]        i_wr_addr,
   input  logic [3:0]        i_wr_data,
   input  logic              i_wr_dp,
   output logic              o_wr_ready,
   input  logic [DIGITS-1:0] i_dig_en,
   output logic [7:0]        o_seg,
   output logic [DIGITS-1:0] o_an,
   output logic              o_frame_tick
);

   localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [2:0]       IDX_LAST   = 3'(DIGITS - 1);

   seg_state_t       state, nstate;
   logic [CNT_W-1:0] cnt, ncnt;
   logic [2:0]       idx, nidx;
   logic [3:0]       value [8];
   logic [7:0]       dp_reg;

   logic       wr_fire, wr_hit, lit, show_dp;
   logic [3:0] show_val;
   logic [6:0] seg_on;
   logic [7:0] en_pad;

   always_comb begin
      nstate = state;
      ncnt   = cnt + CNT_W'(1);
      nidx   = idx;
      case (state)
         ST_IDLE: begin
            nstate = ST_BLANK;
            ncnt   = '0;
         end
         ST_BLANK: begin
            if (cnt == BLANK_LAST) begin
               nstate = ST_SHOW;
               ncnt   = '0;
            end
         end
         ST_SHOW: begin
            if (cnt == SHOW_LAST) begin
               nstate = ST_BLANK;
               ncnt   = '0;
               nidx   = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
            end
         end
         default: begin
            nstate = ST_IDLE;
            ncnt   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state, so a write landing on the
   // edge that enters SHOW must be forwarded to the digit being lit.
   assign en_pad   = 8'(i_dig_en);
   assign wr_fire  = i_wr_valid && o_wr_ready && ({1'b0, i_wr_addr} < 4'(DIGITS));
   assign wr_hit   = wr_fire && (i_wr_addr == nidx);
   assign show_val = wr_hit ? i_wr_data : value[nidx];
   assign show_dp  = wr_hit ? i_wr_dp : dp_reg[nidx];
   assign lit      = (nstate == ST_SHOW) && en_pad[nidx];

   seg_hex_dec u_dec (
      .hex (show_val),
      .seg (seg_on)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         idx          <= '0;
         for (int i = 0; i < 8; i++) value[i] <= 4'h0;
         dp_reg       <= '0;
         o_seg        <= 8'hFF;
         o_an         <= '1;
         o_wr_ready   <= 1'b0;
         o_frame_tick <= 1'b0;
      end else begin
         state <= nstate;
         cnt   <= ncnt;
         idx   <= nidx;
         if (wr_fire) begin
            value[i_wr_addr]  <= i_wr_data;
            dp_reg[i_wr_addr] <= i_wr_dp;
         end
         o_seg        <= lit ? ~{seg_on, show_dp} : 8'hFF;
         o_an         <= lit ? ~(DIGITS'(1) << nidx) : '1;
         o_wr_ready   <= (nstate != ST_SHOW);
         o_frame_tick <= (nstate == ST_SHOW) && (ncnt == SHOW_LAST) && (nidx == IDX_LAST);
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a 4-digit, short-slot configuration.
module tb_seg_scan_ctrl;

   localparam int DIGITS = 4, SCAN_DIV = 4, BLANK_CYC = 2;
   localparam int SLOT = 6, FRAME = 24;

   logic       clk = 1'b0;
   logic       rst, i_wr_valid, i_wr_dp, o_wr_ready, o_frame_tick;
   logic [2:0] i_wr_addr;
   logic [3:0] i_wr_data, i_dig_en, o_an;
   logic [7:0] o_seg;

   int n_cmp = 0, n_fail = 0, cyc = 0;

   logic [3:0] m_val [4];
   logic [3:0] m_dp, m_en;

   localparam logic [6:0] DEC [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_wr_valid   (i_wr_valid),
      .i_wr_addr    (i_wr_addr),
      .i_wr_data    (i_wr_data),
      .i_wr_dp      (i_wr_dp),
      .o_wr_ready   (o_wr_ready),
      .i_dig_en     (i_dig_en),
      .o_seg        (o_seg),
      .o_an         (o_an),
      .o_frame_tick (o_frame_tick)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] exp_an(int c);
      int p, s, w;
      if (c < 1) return 4'hF;
      p = (c - 1) % FRAME; s = p / SLOT; w = p % SLOT;
      if (w < BLANK_CYC || !m_en[s]) return 4'hF;
      return ~(4'b0001 << s);
   endfunction

   function automatic logic [7:0] exp_seg(int c);
      int p, s, w;
      if (c < 1) return 8'hFF;
      p = (c - 1) % FRAME; s = p / SLOT; w = p % SLOT;
      if (w < BLANK_CYC || !m_en[s]) return 8'hFF;
      return ~{DEC[m_val[s]], m_dp[s]};
   endfunction

   function automatic logic exp_tick(int c);
      return (c >= 1) && ((c - 1) % FRAME == FRAME - 1);
   endfunction

   function automatic logic exp_ready(int c);
      return (c >= 1) && (((c - 1) % FRAME) % SLOT < BLANK_CYC);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_wr_valid = 1'b0; i_wr_addr = 3'd0; i_wr_data = 4'h0;
      i_wr_dp = 1'b0; i_dig_en = 4'hF;
      m_en = 4'hF; m_dp = 4'h0;
      for (int i = 0; i < 4; i++) m_val[i] = 4'h0;
      repeat (3) tick();
      n_cmp++; if (o_an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %b want 1111", o_an); end
      n_cmp++; if (o_seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h want ff", o_seg); end
      n_cmp++; if (o_wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", o_wr_ready); end
      n_cmp++; if (o_frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", o_frame_tick); end
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_scan();
      int ticks = 0, last = -1;
      for (int k = 0; k < 2 * FRAME; k++) begin
         tick();
         n_cmp++; if (o_an !== exp_an(cyc)) begin n_fail++; $display("FAIL scan_an c%0d: got %b want %b", cyc, o_an, exp_an(cyc)); end
         n_cmp++; if (o_seg !== exp_seg(cyc)) begin n_fail++; $display("FAIL scan_seg c%0d: got %h want %h", cyc, o_seg, exp_seg(cyc)); end
         n_cmp++; if (o_frame_tick !== exp_tick(cyc)) begin n_fail++; $display("FAIL scan_tick c%0d: got %b want %b", cyc, o_frame_tick, exp_tick(cyc)); end
         n_cmp++; if (o_wr_ready !== exp_ready(cyc)) begin n_fail++; $display("FAIL scan_ready c%0d: got %b want %b", cyc, o_wr_ready, exp_ready(cyc)); end
         if (o_frame_tick === 1'b1) begin
            if (last >= 0) begin
               n_cmp++; if (cyc - last != FRAME) begin n_fail++; $display("FAIL tick_period: got %0d want %0d", cyc - last, FRAME); end
            end
            last = cyc; ticks++;
         end
      end
      n_cmp++; if (ticks != 2) begin n_fail++; $display("FAIL tick_count: got %0d want 2", ticks); end
   endtask

   task automatic test_write_blank();
      bit seen = 0;
      for (int k = 0; k < 30 && !exp_ready(cyc); k++) tick();
      n_cmp++; if (o_wr_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready_blank: got %b want 1", o_wr_ready); end
      i_wr_valid = 1'b1; i_wr_addr = 3'd2; i_wr_data = 4'hA; i_wr_dp = 1'b1;
      tick();
      i_wr_valid = 1'b0;
      m_val[2] = 4'hA; m_dp[2] = 1'b1;
      for (int k = 0; k < 30; k++) begin
         n_cmp++; if (o_an !== exp_an(cyc)) begin n_fail++; $display("FAIL wr_an c%0d: got %b want %b", cyc, o_an, exp_an(cyc)); end
         n_cmp++; if (o_seg !== exp_seg(cyc)) begin n_fail++; $display("FAIL wr_seg c%0d: got %h want %h", cyc, o_seg, exp_seg(cyc)); end
         if (exp_an(cyc) == 4'b1011 && !seen) begin
            seen = 1;
            n_cmp++; if (o_an !== 4'b1011 || o_seg !== 8'b0001_0000) begin
               n_fail++; $display("FAIL wr_digit2: got an=%b seg=%b want an=1011 seg=00010000", o_an, o_seg);
            end
         end
         tick();
      end
      n_cmp++; if (!seen) begin n_fail++; $display("FAIL wr_digit2_slot: got none want one slot"); end
   endtask

   task automatic test_write_hold();
      logic [7:0] seg0;
      for (int k = 0; k < 30 && exp_ready(cyc); k++) tick();
      seg0 = o_seg;
      i_wr_valid = 1'b1; i_wr_addr = 3'd0; i_wr_data = 4'h5; i_wr_dp = 1'b0;
      for (int k = 0; k < SCAN_DIV + 1; k++) begin
         tick();
         if (exp_ready(cyc)) break;
         n_cmp++; if (o_wr_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready c%0d: got %b want 0", cyc, o_wr_ready); end
         n_cmp++; if (o_seg !== seg0) begin n_fail++; $display("FAIL hold_seg c%0d: got %h want %h", cyc, o_seg, seg0); end
      end
      n_cmp++; if (o_wr_ready !== 1'b1) begin n_fail++; $display("FAIL hold_accept_ready: got %b want 1", o_wr_ready); end
      tick();
      i_wr_valid = 1'b0;
      m_val[0] = 4'h5; m_dp[0] = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
         n_cmp++; if (o_an !== exp_an(cyc)) begin n_fail++; $display("FAIL hold_an c%0d: got %b want %b", cyc, o_an, exp_an(cyc)); end
         n_cmp++; if (o_seg !== exp_seg(cyc)) begin n_fail++; $display("FAIL hold_seg_after c%0d: got %h want %h", cyc, o_seg, exp_seg(cyc)); end
         tick();
      end
   endtask

   task automatic test_dig_en();
      int ticks = 0;
      i_dig_en = 4'b0101; m_en = 4'b0101;
      for (int k = 0; k < FRAME; k++) begin
         tick();
         n_cmp++; if (o_an !== exp_an(cyc)) begin n_fail++; $display("FAIL en_an c%0d: got %b want %b", cyc, o_an, exp_an(cyc)); end
         n_cmp++; if (o_seg !== exp_seg(cyc)) begin n_fail++; $display("FAIL en_seg c%0d: got %h want %h", cyc, o_seg, exp_seg(cyc)); end
         n_cmp++; if (o_an === 4'b1101 || o_an === 4'b0111) begin n_fail++; $display("FAIL en_dark c%0d: got %b want digits 1,3 dark", cyc, o_an); end
         if (o_frame_tick === 1'b1) ticks++;
      end
      n_cmp++; if (ticks != 1) begin n_fail++; $display("FAIL en_frame: got %0d ticks want 1", ticks); end
      i_dig_en = 4'hF; m_en = 4'hF;
   endtask

   task automatic test_bad_addr();
      for (int k = 0; k < 30 && !exp_ready(cyc); k++) tick();
      i_wr_valid = 1'b1; i_wr_addr = 3'd6; i_wr_data = 4'hF; i_wr_dp = 1'b1;
      tick();
      i_wr_valid = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
         tick();
         n_cmp++; if (o_an !== exp_an(cyc)) begin n_fail++; $display("FAIL bad_an c%0d: got %b want %b", cyc, o_an, exp_an(cyc)); end
         n_cmp++; if (o_seg !== exp_seg(cyc)) begin n_fail++; $display("FAIL bad_seg c%0d: got %h want %h", cyc, o_seg, exp_seg(cyc)); end
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 30 && exp_an(cyc) != 4'b0111; k++) tick();
      n_cmp++; if (o_an !== 4'b0111) begin n_fail++; $display("FAIL mid_pre_an: got %b want 0111", o_an); end
      rst = 1'b1;
      i_wr_valid = 1'b1; i_wr_addr = 3'd1; i_wr_data = 4'h9; i_wr_dp = 1'b1;
      tick();
      n_cmp++; if (o_an !== 4'hF) begin n_fail++; $display("FAIL mid_an: got %b want 1111", o_an); end
      n_cmp++; if (o_seg !== 8'hFF) begin n_fail++; $display("FAIL mid_seg: got %h want ff", o_seg); end
      rst = 1'b0; i_wr_valid = 1'b0;
      cyc = 0;
      for (int i = 0; i < 4; i++) m_val[i] = 4'h0;
      m_dp = 4'h0;
      for (int k = 0; k < FRAME; k++) begin
         tick();
         n_cmp++; if (o_an !== exp_an(cyc)) begin n_fail++; $display("FAIL mid_scan_an c%0d: got %b want %b", cyc, o_an, exp_an(cyc)); end
         n_cmp++; if (o_seg !== exp_seg(cyc)) begin n_fail++; $display("FAIL mid_scan_seg c%0d: got %h want %h", cyc, o_seg, exp_seg(cyc)); end
         if (cyc == 3) begin
            n_cmp++; if (o_an !== 4'b1110 || o_seg !== 8'b0000_0011) begin
               n_fail++; $display("FAIL mid_digit0: got an=%b seg=%b want an=1110 seg=00000011", o_an, o_seg);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      n_cmp++; if (o_an !== 4'hF) begin n_fail++; $display("FAIL cycle0_an: got %b want 1111", o_an); end
      test_scan();
      test_write_blank();
      test_write_hold();
      test_dig_en();
      test_bad_addr();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
